// File: rtl/clock_pkg.sv
// Shared state encoding, default moduli and field widths for the time-of-day set controller.
// Alarm states are only reachable when CLOCK_ALARM_EN is defined.
package clock_pkg;

    localparam int SEC_MOD_DEF  = 20;
    localparam int MIN_MOD_DEF  = 10;
    localparam int HOUR_MOD_DEF = 5;

    localparam int SEC_W  = 5;
    localparam int MIN_W  = 4;
    localparam int HOUR_W = 3;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_S  = 3'd3,
        SET_AH = 3'd4,
        SET_AM = 3'd5
    } state_t;

    // One-hot {hour,min,sec} highlight for the field being edited.
    function automatic logic [2:0] field_of(input state_t st);
        case (st)
            SET_H, SET_AH: return 3'b100;
            SET_M, SET_AM: return 3'b010;
            SET_S:         return 3'b001;
            default:       return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mod_field.sv
// Single modulo-MOD time field: advances with carry-out, or is nudged up/down without carry.
// Used for hour/min/sec and, with CLOCK_ALARM_EN, for the alarm fields.
module mod_field
    import clock_pkg::*;
#(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         carry_out
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    assign carry_out = adv && (value == TOP);

    // inc and dec together cancel; adv and inc/dec are never asserted together by the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (adv || (inc && !dec)) begin
            value <= (value == TOP) ? '0 : value + W'(1);
        end else if (dec && !inc) begin
            value <= (value == '0) ? TOP : value - W'(1);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set controller owning the hour/min/sec counter chain, with button-driven field editing.
// Define CLOCK_ALARM_EN to add alarm registers, the SET_AH/SET_AM states and the alarm_hit pulse.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int SEC_MOD   = SEC_MOD_DEF,
    parameter int MIN_MOD   = MIN_MOD_DEF,
    parameter int HOUR_MOD  = HOUR_MOD_DEF,
    parameter int BLINK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic [2:0]        field_sel,
    output logic              blink,
    output logic              alarm_hit
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t            state;
    state_t            nxt;
    logic              mode_q, inc_q, dec_q;
    logic              mode_ev, inc_ev, dec_ev;
    logic              running, edit_ok, adjust;
    logic [BW-1:0]     blink_cnt;
    logic [HOUR_W-1:0] hour_t;
    logic [MIN_W-1:0]  min_t;
    logic [SEC_W-1:0]  sec_t;
    logic              sec_carry, min_carry, hour_carry;
    logic              carry_unused;

    assign mode_ev = btn_mode & ~mode_q;
    assign inc_ev  = btn_inc  & ~inc_q;
    assign dec_ev  = btn_dec  & ~dec_q;

    assign running = (state == RUN);
    // A mode event always wins over a same-cycle inc/dec.
    assign edit_ok = !running && !mode_ev;
    assign adjust  = edit_ok && (inc_ev ^ dec_ev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
        end else begin
            mode_q <= btn_mode;
            inc_q  <= btn_inc;
            dec_q  <= btn_dec;
        end
    end

    always_comb begin
        nxt = state;
        if (mode_ev) begin
            case (state)
                RUN:    nxt = SET_H;
                SET_H:  nxt = SET_M;
                SET_M:  nxt = SET_S;
`ifdef CLOCK_ALARM_EN
                SET_S:  nxt = SET_AH;
                SET_AH: nxt = SET_AM;
                SET_AM: nxt = RUN;
`else
                SET_S:  nxt = RUN;
                SET_AH: nxt = RUN;
                SET_AM: nxt = RUN;
`endif
                default: nxt = RUN;
            endcase
        end
    end

    // Blink restarts visible after every edit and is parked low whenever the clock runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            field_sel <= 3'b000;
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            state     <= nxt;
            field_sel <= field_of(nxt);
            if (nxt == RUN) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (adjust) begin
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (!running) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    mod_field #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk(clk), .rst(rst), .adv(running && tick),
        .inc(edit_ok && inc_ev && state == SET_S),
        .dec(edit_ok && dec_ev && state == SET_S),
        .value(sec_t), .carry_out(sec_carry)
    );

    mod_field #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk(clk), .rst(rst), .adv(sec_carry),
        .inc(edit_ok && inc_ev && state == SET_M),
        .dec(edit_ok && dec_ev && state == SET_M),
        .value(min_t), .carry_out(min_carry)
    );

    mod_field #(.MOD(HOUR_MOD), .W(HOUR_W)) u_hour (
        .clk(clk), .rst(rst), .adv(min_carry),
        .inc(edit_ok && inc_ev && state == SET_H),
        .dec(edit_ok && dec_ev && state == SET_H),
        .value(hour_t), .carry_out(hour_carry)
    );

    assign sec = sec_t;

`ifdef CLOCK_ALARM_EN
    logic [HOUR_W-1:0] alarm_h;
    logic [MIN_W-1:0]  alarm_m;
    logic [HOUR_W-1:0] hour_next;
    logic [MIN_W-1:0]  min_next;
    logic              ah_carry, am_carry;
    logic              show_alarm;

    mod_field #(.MOD(HOUR_MOD), .W(HOUR_W)) u_alarm_h (
        .clk(clk), .rst(rst), .adv(1'b0),
        .inc(edit_ok && inc_ev && state == SET_AH),
        .dec(edit_ok && dec_ev && state == SET_AH),
        .value(alarm_h), .carry_out(ah_carry)
    );

    mod_field #(.MOD(MIN_MOD), .W(MIN_W)) u_alarm_m (
        .clk(clk), .rst(rst), .adv(1'b0),
        .inc(edit_ok && inc_ev && state == SET_AM),
        .dec(edit_ok && dec_ev && state == SET_AM),
        .value(alarm_m), .carry_out(am_carry)
    );

    assign carry_unused = ah_carry ^ am_carry;
    assign show_alarm   = (state == SET_AH) || (state == SET_AM);
    assign hour         = show_alarm ? alarm_h : hour_t;
    assign min          = show_alarm ? alarm_m : min_t;

    // The time this tick lands on; only meaningful when sec_carry is set.
    assign min_next  = min_carry ? '0 : min_t + MIN_W'(1);
    assign hour_next = hour_carry ? '0 : (min_carry ? hour_t + HOUR_W'(1) : hour_t);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_hit <= 1'b0;
        end else begin
            alarm_hit <= sec_carry && (min_next == alarm_m) && (hour_next == alarm_h);
        end
    end
`else
    assign carry_unused = hour_carry;
    assign hour         = hour_t;
    assign min          = min_t;
    assign alarm_hit    = 1'b0;
`endif

endmodule
